// File: rtl/mem_pkg.sv
// Shared FSM state type and default sizing for the burst memory controller.
// Latency: none (types and constants only).
// Backpressure: none.
package mem_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 11;
  localparam int DEF_MAX_BURST = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD       = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/sram_array.sv
// Single-port-per-direction word array: synchronous write, registered read.
// Latency: read data appears one clock after the read enable is sampled.
// Backpressure: none; every enabled access completes in one cycle.
module sram_array
  import mem_pkg::*;
#(
  parameter int WIDTH  = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // Array write; deliberately no reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  // Registered read port; only the output register is cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      rdata <= '0;
    else if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst read/write controller over sram_array; optional parity via MEM_PARITY_EN.
// Latency: one beat per cycle, read data one cycle after issue, done after last beat.
// Backpressure: write beats stall on wvalid=0 (wready held); reads cannot be stalled.
module mem_burst_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int BL_W     = $clog2(MAX_BURST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BL_W-1:0]   len_m1,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              done,
  output logic              rerr
);

  localparam logic [BL_W-1:0] LEN_MAX = BL_W'(MAX_BURST - 1);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [BL_W-1:0]   cnt_q, cnt_d;
  logic [BL_W-1:0]   len_clamped;
  logic              mem_we, mem_re, done_d;
  logic [MEM_W-1:0]  mem_wdata, mem_rdata;

  assign len_clamped = (len_m1 > LEN_MAX) ? LEN_MAX : len_m1;
  assign busy        = (state_q != IDLE);

`ifdef MEM_PARITY_EN
  // Stored bit makes the whole word even parity; any odd word read back is corrupt.
  assign mem_wdata = {^wdata, wdata};
  assign rdata     = mem_rdata[DATA_W-1:0];
  assign rerr      = rvalid & (^mem_rdata);
`else
  assign mem_wdata = wdata;
  assign rdata     = mem_rdata;
  assign rerr      = 1'b0;
`endif

  // State, address and beat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mar_q   <= '0;
      cnt_q   <= '0;
      rvalid  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      cnt_q   <= cnt_d;
      rvalid  <= mem_re;
      done    <= done_d;
    end
  end

  // Next-state, beat sequencing and array strobes.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    done_d  = 1'b0;
    wready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          mar_d   = addr;
          cnt_d   = len_clamped;
          state_d = we ? WR : RD;
        end
      end
      WR: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_we = 1'b1;
          mar_d  = mar_q + ADDR_W'(1);
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - BL_W'(1);
          end
        end
      end
      RD: begin
        // done is registered alongside rvalid, so it lands on the last data beat.
        mem_re = 1'b1;
        mar_d  = mar_q + ADDR_W'(1);
        if (cnt_q == '0) begin
          state_d = RD_DRAIN;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - BL_W'(1);
        end
      end
      RD_DRAIN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  sram_array #(
    .WIDTH  (MEM_W),
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clk   (clk),
    .rst   (rst),
    .wen   (mem_we),
    .waddr (mar_q),
    .wdata (mem_wdata),
    .ren   (mem_re),
    .raddr (mar_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed plus randomized bench for mem_burst_ctrl against an array memory model.
// Latency: expects data one cycle after each read issue, done on last beat.
// Backpressure: drives random wvalid gaps and stray req pulses during bursts.
`timescale 1ns/1ps
module tb_mem_burst_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 11;
  localparam int BLW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [BLW-1:0] len_m1;
  logic [DW-1:0] wdata;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          busy;
  logic          done;
  logic          rerr;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] model [2**AW];

  mem_burst_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .len_m1 (len_m1),
    .wdata  (wdata),
    .wvalid (wvalid),
    .wready (wready),
    .rdata  (rdata),
    .rvalid (rvalid),
    .busy   (busy),
    .done   (done),
    .rerr   (rerr)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write burst: gap_mode 0 = wvalid always, 1 = pattern (LSB first), 2 = random.
  task automatic wr_burst(input logic [AW-1:0] a, input int l, input int base,
                          input int gap_mode, input logic [7:0] pat, input bit noise);
    logic [AW-1:0] p;
    logic [DW-1:0] d;
    logic          v;
    int            acc;
    int            step;
    p = a; acc = 0; step = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; len_m1 = BLW'(l);
    @(negedge clk);
    req = 1'b0;
    while (acc <= l && step < 64) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (step < 8) ? pat[step] : 1'b1;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d = (base >= 0) ? DW'(base + acc) : DW'($urandom);
      chk("wr_wready", 32'(wready), 1);
      chk("wr_busy",   32'(busy),   1);
      chk("wr_rvalid", 32'(rvalid), 0);
      chk("wr_done",   32'(done),   0);
      wvalid = v;
      wdata  = d;
      if (noise) begin
        req    = 1'($urandom_range(0, 1));
        we     = 1'($urandom_range(0, 1));
        addr   = AW'($urandom);
        len_m1 = BLW'($urandom);
      end
      if (v) begin
        model[p] = d;
        p++;
        acc++;
      end
      step++;
      @(negedge clk);
    end
    wvalid = 1'b0;
    req    = 1'b0;
    chk("wr_accepted",   32'(acc),    32'(l + 1));
    chk("wr_done_pulse", 32'(done),   1);
    chk("wr_end_busy",   32'(busy),   0);
    chk("wr_end_wready", 32'(wready), 0);
    @(negedge clk);
    chk("wr_done_clear", 32'(done), 0);
  endtask

  // Read burst with stray req noise; err_beat expects rerr, abort_at fires reset.
  task automatic rd_burst(input logic [AW-1:0] a, input int l, input int err_beat,
                          input int abort_at);
    logic [AW-1:0] p;
    p = a;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a; len_m1 = BLW'(l);
    @(negedge clk);
    req = 1'b0; addr = AW'($urandom); len_m1 = BLW'($urandom);
    chk("rd_start_busy",   32'(busy),   1);
    chk("rd_start_rvalid", 32'(rvalid), 0);
    for (int i = 0; i <= l; i++) begin
      @(negedge clk);
      req = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      chk("rd_rvalid", 32'(rvalid), 1);
      chk("rd_wready", 32'(wready), 0);
      chk("rd_data",   32'(rdata),  32'(model[p]));
      chk("rd_rerr",   32'(rerr),   32'(i == err_beat));
      chk("rd_done",   32'(done),   32'(i == l));
      chk("rd_busy",   32'(busy),   1);
      p++;
      if (i == abort_at) begin
        req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata",  32'(rdata),  0);
        chk("rst_busy",   32'(busy),   0);
        chk("rst_done",   32'(done),   0);
        chk("rst_wready", 32'(wready), 0);
        chk("rst_rerr",   32'(rerr),   0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("post_rst_done",   32'(done),   0);
          chk("post_rst_busy",   32'(busy),   0);
          chk("post_rst_rvalid", 32'(rvalid), 0);
        end
        return;
      end
    end
    @(negedge clk);
    req = 1'b0;
    chk("rd_end_busy",   32'(busy),   0);
    chk("rd_end_rvalid", 32'(rvalid), 0);
    chk("rd_end_done",   32'(done),   0);
  endtask

  initial begin
    logic [AW-1:0] ra;
    int            rl;
    int            perr;
    perr   = -1;
    rst    = 1'b1;
    req    = 1'b0;
    we     = 1'b0;
    addr   = '0;
    len_m1 = '0;
    wdata  = '0;
    wvalid = 1'b0;
    #12;
    chk("reset_wready", 32'(wready), 0);
    chk("reset_rvalid", 32'(rvalid), 0);
    chk("reset_rdata",  32'(rdata),  0);
    chk("reset_busy",   32'(busy),   0);
    chk("reset_done",   32'(done),   0);
    chk("reset_rerr",   32'(rerr),   0);
    @(negedge clk);
    rst = 1'b0;

    // Basic four-beat write then readback of 0xA000..0xA003.
    wr_burst(11'h010, 3, 'hA000, 0, 8'h00, 1'b0);
    rd_burst(11'h010, 3, -1, -1);

    // Fill a region, then overwrite three words with wvalid gaps; neighbours untouched.
    wr_burst(11'h100, 7, -1, 0, 8'h00, 1'b0);
    wr_burst(11'h100, 2, -1, 1, 8'b0001_0101, 1'b0);
    rd_burst(11'h100, 7, -1, -1);

    // Address wrap across the top of memory.
    wr_burst(11'h7FE, 3, -1, 0, 8'h00, 1'b0);
    rd_burst(11'h7FE, 3, -1, -1);

    // Stray req/we/addr activity during an 8-beat write with random gaps.
    wr_burst(11'h200, 7, -1, 2, 8'h00, 1'b1);
    rd_burst(11'h200, 7, -1, -1);

    // Randomized bursts.
    for (int n = 0; n < 8; n++) begin
      ra = AW'($urandom);
      rl = $urandom_range(0, 7);
      wr_burst(ra, rl, -1, 2, 8'h00, 1'b1);
      rd_burst(ra, rl, -1, -1);
    end
    wr_burst(11'h200, 7, -1, 0, 8'h00, 1'b0);

`ifdef MEM_PARITY_EN
    // Corrupt one stored data bit; only that beat may flag rerr.
    dut.u_sram.mem[11'h202][5] = ~dut.u_sram.mem[11'h202][5];
    model[11'h202][5] = ~model[11'h202][5];
    perr = 2;
`endif
    rd_burst(11'h200, 7, perr, -1);

    // Reset on the second beat of an 8-beat read, then confirm contents survived.
    rd_burst(11'h200, 7, perr, 1);
    rd_burst(11'h200, 7, perr, -1);
    rd_burst(11'h010, 3, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
